// File: rtl/alu_arbiter_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter_seq: round-robin shared 16-bit ALU with result hold/status    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_arbiter_seq #(
  parameter int N_REQ = 2,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 rsp_z,
  output logic                 rsp_v,
  output logic                 rsp_n,
  output logic [2:0]           status,
  output logic                 busy
);

  localparam logic [1:0]     c_st_idle   = 2'd0;
  localparam logic [1:0]     c_st_exec   = 2'd1;
  localparam logic [1:0]     c_st_resp   = 2'd2;
  localparam logic [IDW-1:0] c_last_init = IDW'(N_REQ - 1);

  logic [1:0]     r_state;
  logic [1:0]     w_next_state;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_id;
  logic [1:0]     r_op;
  logic [15:0]    r_a;
  logic [15:0]    r_b;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [15:0]    r_rsp_data;
  logic           r_rsp_z;
  logic           r_rsp_v;
  logic           r_rsp_n;
  logic [2:0]     r_status;

  logic           w_any;
  logic [IDW-1:0] w_gidx;
  logic           w_accept;
  logic [1:0]     w_sel_op;
  logic [15:0]    w_sel_a;
  logic [15:0]    w_sel_b;
  logic [15:0]    w_b_eff;
  logic [16:0]    w_sum;
  logic [15:0]    w_res;
  logic           w_v;
  logic           w_z;
  logic           w_n;

  // Round-robin: indices above last_grant beat those at or below it; the
  // lowest index inside each group wins, so the second pass overrides the first.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i <= int'(r_last_grant))) begin
        w_any  = 1'b1;
        w_gidx = IDW'(i);
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(r_last_grant))) begin
        w_any  = 1'b1;
        w_gidx = IDW'(i);
      end
    end
  end

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gidx == IDW'(i)) begin
        w_sel_op = req_op[2*i +: 2];
        w_sel_a  = req_a[16*i +: 16];
        w_sel_b  = req_b[16*i +: 16];
      end
    end
  end

  assign w_accept = (r_state == c_st_idle) && w_any;

  // ALU sees only the latched operands so requester changes cannot leak in.
  always_comb begin
    w_b_eff = (r_op == 2'b01) ? ~r_b : r_b;
    w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {16'd0, (r_op == 2'b01)};
    w_res   = '0;
    w_v     = 1'b0;
    case (r_op)
      2'b00, 2'b01: begin
        w_res = w_sum[15:0];
        w_v   = (r_a[15] ^ w_b_eff[15] ^ w_sum[15]) ^ w_sum[16];
      end
      2'b10:   w_res = r_a & r_b;
      default: w_res = ~r_b;
    endcase
    w_z = (w_res == 16'h0000);
    w_n = w_res[15];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_next_state = c_st_exec;
      c_st_exec: w_next_state = c_st_resp;
      c_st_resp: if (rsp_ready) w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = (r_state != c_st_idle);
    if (r_state == c_st_idle) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_ready[i] = w_any && (w_gidx == IDW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= c_last_init;
      r_id         <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_gidx;
      r_id         <= w_gidx;
      r_op         <= w_sel_op;
      r_a          <= w_sel_a;
      r_b          <= w_sel_b;
    end
  end

  // Response fields keep their value after the handshake; only valid drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_v     <= 1'b0;
      r_rsp_n     <= 1'b0;
      r_status    <= '0;
    end else if (r_state == c_st_exec) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_data  <= w_res;
      r_rsp_z     <= w_z;
      r_rsp_v     <= w_v;
      r_rsp_n     <= w_n;
      r_status    <= {w_z, w_v, w_n};
    end else if ((r_state == c_st_resp) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_z     = r_rsp_z;
  assign rsp_v     = r_rsp_v;
  assign rsp_n     = r_rsp_n;
  assign status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter_seq: directed self-checking bench for alu_arbiter_seq      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter_seq;

  localparam int N_REQ = 2;
  localparam int IDW   = 2;

  logic                clk;
  logic                reset_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [2*N_REQ-1:0]  req_op;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_data;
  logic                rsp_z;
  logic                rsp_v;
  logic                rsp_n;
  logic [2:0]          status;
  logic                busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter_seq #(.N_REQ(N_REQ), .IDW(IDW)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_z     (rsp_z),
    .rsp_v     (rsp_v),
    .rsp_n     (rsp_n),
    .status    (status),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[2*idx +: 2] = op;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
  endtask

  // One isolated transaction from requester idx with full response checking.
  task automatic run_op(input int idx, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input logic [2:0] exp_zvn);
    int n;
    @(negedge clk);
    set_req(idx, op, a, b);
    req_valid = N_REQ'(1 << idx);
    #1 chk("ready_onehot", 32'(req_ready), 32'(1 << idx));
    @(negedge clk);
    req_valid = '0;
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd2);
    chk("rsp_id", 32'(rsp_id), 32'(idx));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_zvn", 32'({rsp_z, rsp_v, rsp_n}), 32'(exp_zvn));
    chk("status", 32'(status), 32'(exp_zvn));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
    chk("rsp_data_hold", 32'(rsp_data), 32'(exp_d));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int          ngr;
    int          g_cyc [4];
    logic [1:0]  g_val [4];
    int          n;

    reset_n   = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b1;

    run_op(0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b011);
    run_op(1, 2'b01, 16'h0005, 16'h0005, 16'h0000, 3'b100);
    run_op(0, 2'b11, 16'h1234, 16'h00FF, 16'hFF00, 3'b001);
    run_op(1, 2'b10, 16'hF0F0, 16'h0F0F, 16'h0000, 3'b100);

    // Both requesters held valid, consumer always ready: expect 0,1,0,1 every 3 cycles.
    @(negedge clk);
    set_req(0, 2'b00, 16'h0001, 16'h0002);
    set_req(1, 2'b01, 16'h0010, 16'h0001);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ngr = 0;
    for (int cyc = 0; cyc < 30 && ngr < 4; cyc++) begin
      #1;
      if (req_ready != '0) begin
        g_cyc[ngr] = cyc;
        g_val[ngr] = req_ready;
        ngr++;
      end
      if (rsp_valid) begin
        chk("rr_data", 32'(rsp_data), (rsp_id == 0) ? 32'h0003 : 32'h000F);
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_count", 32'(ngr), 32'd4);
    if (ngr == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_grant", 32'(g_val[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
        if (k > 0) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
      end
    end
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rr_drain", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // Stall in RESP with other requests pending.
    @(negedge clk);
    set_req(1, 2'b00, 16'h8000, 16'h1234);
    req_valid = 2'b10;
    #1 chk("stall_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id", 32'(rsp_id), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'h9234);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_release", 32'(rsp_valid), 32'd0);
    chk("stall_status", 32'(status), 32'b001);

    // Reset while EXEC: outputs clear at once and round-robin pointer restarts.
    @(negedge clk);
    set_req(0, 2'b00, 16'h0001, 16'h0001);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_id", 32'(rsp_id), 32'd0);
    chk("arst_data", 32'(rsp_data), 32'd0);
    chk("arst_n", 32'(rsp_n), 32'd0);
    chk("arst_status", 32'(status), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 2'b11;
    #1 chk("post_rst_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("post_rst_data", 32'(rsp_data), 32'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
